// File: rtl/scan_controller_if.sv
// rtl/scan_controller_if.sv - start/done handshake and datapath issue bundle for scan_controller
interface scan_controller_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 10
);
    logic             start;
    logic [ROW_W-1:0] rows;
    logic [COL_W-1:0] cols;
    logic             stall;
    logic             busy;
    logic             issue;
    logic [ROW_W-1:0] row_idx;
    logic [COL_W-1:0] col_idx;
    logic             row_end;
    logic             done;
    logic             err;

    modport master (
        output start, rows, cols, stall,
        input  busy, issue, row_idx, col_idx, row_end, done, err
    );

    modport slave (
        input  start, rows, cols, stall,
        output busy, issue, row_idx, col_idx, row_end, done, err
    );
endinterface

// File: rtl/scan_controller.sv
// rtl/scan_controller.sv - row/column nested-loop sequencer with stall and pipeline drain
module scan_controller #(
    parameter int ROW_W     = 4,
    parameter int COL_W     = 10,
    parameter int DRAIN_CYC = 2
) (
    input  logic               clk,
    input  logic               rst,
    scan_controller_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
    localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYC - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] rows_r_q, rows_r_d;
    logic [COL_W-1:0] cols_r_q, cols_r_d;
    logic [3:0]       drain_q, drain_d;
    logic             err_r_q, err_r_d;

    logic             issue_w;
    logic             col_last;
    logic             row_last;

    // Issue/end-of-row decode; bounds compare only against the latched copies
    always_comb begin
        issue_w  = (state_q == S_RUN) && !bus.stall;
        col_last = (col_q == cols_r_q - COL_ONE);
        row_last = (row_q == rows_r_q - ROW_ONE);
    end

    assign bus.issue   = issue_w;
    assign bus.row_end = issue_w && col_last;
    assign bus.row_idx = row_q;
    assign bus.col_idx = col_q;
    assign bus.busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.err     = (state_q == S_DONE) && err_r_q;

    // Next-state: capture bounds, walk row-major indices, count out the drain
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        rows_r_d = rows_r_q;
        cols_r_d = cols_r_q;
        drain_d  = drain_q;
        err_r_d  = err_r_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rows_r_d = bus.rows;
                    cols_r_d = bus.cols;
                    if ((bus.rows == '0) || (bus.cols == '0)) begin
                        err_r_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issue_w) begin
                    if (col_last) begin
                        col_d = '0;
                        if (row_last) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + ROW_ONE;
                        end
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    drain_d = '0;
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            S_DONE: begin
                err_r_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any scan without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            rows_r_q <= '0;
            cols_r_q <= '0;
            drain_q  <= '0;
            err_r_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            rows_r_q <= rows_r_d;
            cols_r_q <= cols_r_d;
            drain_q  <= drain_d;
            err_r_q  <= err_r_d;
        end
    end
endmodule

// File: doc/scan_controller.md
# scan_controller

Sequencing controller for the counter-based datapath: walks a two-level nested loop (rows × columns) and issues one datapath operation per cycle, inserting stalls on request. Loop bounds are captured at start; completion is signalled after a fixed pipeline drain. Sits between the top-level start/done handshake and the datapath's counter `inc`/register-enable inputs.

## Interface
- `ROW_W`, 4, row-count and row-index width
- `COL_W`, 10, column-count and column-index width
- `DRAIN_CYC`, 2, datapath pipeline depth to flush after the last issue; legal range 1..15

- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a scan; sampled only in IDLE
- `rows`  in  ROW_W  number of rows; sampled with `start`
- `cols`  in  COL_W  number of columns; sampled with `start`
- `stall`  in  1  datapath cannot accept an operation this cycle
- `busy`  out  1  high in RUN and DRAIN
- `issue`  out  1  operation issued this cycle; datapath increments on it
- `row_idx`  out  ROW_W  row of the current operation
- `col_idx`  out  COL_W  column of the current operation
- `row_end`  out  1  current issue is the last column of its row
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  one-cycle pulse with `done` when a zero bound was given

## Operation
- States: IDLE, RUN, DRAIN, DONE. Registered state; `issue`, `row_end` combinational from state, indices, `stall`.
- IDLE: `busy`=0, indices 0. On `start`=1: latch `rows`→`rows_r`, `cols`→`cols_r`. If either is 0 → DONE with `err_r` set; else → RUN.
- RUN: `issue` = ~`stall`. `stall`=1 holds indices and state.
  - On issue with `col_idx` < `cols_r`−1: `col_idx`+1.
  - On issue with `col_idx` = `cols_r`−1: `row_end`=1, `col_idx`←0; if `row_idx` = `rows_r`−1 → `row_idx`←0, DRAIN; else `row_idx`+1.
- DRAIN: `issue`=0; internal drain counter counts DRAIN_CYC cycles, then → DONE. `stall` ignored.
- DONE: `done`=1 (and `err`=1 if `err_r`), `busy`=0, → IDLE next cycle; `err_r` cleared.
- `start` outside IDLE (including the DONE cycle) is ignored; bounds inputs ignored outside the start cycle.
- Total issues per scan = `rows_r`·`cols_r`, in row-major order, each (row, col) exactly once.
- Indices compare against latched bounds only; changing `rows`/`cols` mid-scan has no effect. No index overflow: max `cols` = 2^COL_W−1.

## Timing
- Reset: state IDLE; `busy`, `issue`, `row_end`, `done`, `err` = 0; `row_idx`, `col_idx`, drain counter, `rows_r`, `cols_r`, `err_r` = 0. Reset mid-scan aborts immediately; no `done` is produced.
- `start` sampled at edge T → RUN from cycle T+1; first `issue` in cycle T+1 if `stall`=0.
- No stalls: issues in cycles T+1 .. T+R·C; DRAIN cycles T+R·C+1 .. T+R·C+DRAIN_CYC; `done` in cycle T+R·C+DRAIN_CYC+1; IDLE (new `start` accepted) at T+R·C+DRAIN_CYC+2.
- Each stalled RUN cycle delays all subsequent events by one cycle.
- Zero bound: `done`=`err`=1 in cycle T+1, no issues, `busy` never asserted.
- `busy` rises in cycle T+1, falls in the DONE cycle.

## Test plan
- Basic: rows=2, cols=3, stall=0, DRAIN_CYC=2, start at T → 6 issues T+1..T+6 with (r,c)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2); `row_end` at T+3, T+6; `done` at T+9, `err`=0.
- Stalls: rows=1, cols=4, stall high in cycles T+2 and T+3 → issues at T+1, T+4, T+5, T+6 with c=0..3; `done` at T+9.
- Zero bound: rows=0, cols=5 → `done`=`err`=1 at T+1, `issue` never 1; repeat with rows=3, cols=0 → same.
- Ignored start / bound change: start again at T+2 with rows=7 during a 2×3 scan → still exactly 6 issues, one `done`.
- Reset mid-run: assert `rst` during the 4th issue of a 2×3 scan → all outputs 0 asynchronously, no `done`; a fresh start then completes a full scan normally.
- Max columns: rows=1, cols=1023 → 1023 issues, c=0..1022, single `row_end` on the last, `done` at T+1023+DRAIN_CYC+1.
